// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if
//   Pixel-in / window-out bus of the 3x3 window generator.
//   master : pixel source side (drives in_valid/in_sof/in_pixel, sees the window bus)
//   slave  : window_gen_3x3 side
//   Signals:
//     in_valid     pixel/sof qualifier
//     in_ready     generator can take a pixel this cycle
//     in_sof       pixel is (0,0) of a new frame
//     in_pixel     RGB444 pixel, R[11:8] G[7:4] B[3:0]
//     win_valid    one-cycle pulse per emitted window
//     window_data  packed 3x3 window {C,L,R,U,D,UL,UR,DL,DR}, 12 bits each
//     frame_done   pulses together with the last window of a frame
interface window_gen_3x3_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_sof;
  logic [11:0]  in_pixel;
  logic         win_valid;
  logic [107:0] window_data;
  logic         frame_done;

  modport master (
    output in_valid, in_sof, in_pixel,
    input  in_ready, win_valid, window_data, frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_pixel,
    output in_ready, win_valid, window_data, frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3
//   Turns a raster-order RGB444 pixel stream into one packed 3x3 window per
//   pixel, zero-padded outside the image. Two line buffers plus a 3x3
//   register window; the window for centre c is emitted one clock after
//   pixel c+IMG_WIDTH+1 is accepted, and the last IMG_WIDTH+1 windows of a
//   frame are flushed out with the input stalled.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     bus          window_gen_3x3_if.slave (pixel in, window out)
//     center_x/y   centre coordinates of the current window, only present
//                  when WINDOW_GEN_COORD_OUT_EN is defined
//   Parameters: IMG_WIDTH >= 2, IMG_HEIGHT >= 2.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic clk,
  input  logic reset,
  window_gen_3x3_if.slave bus
`ifdef WINDOW_GEN_COORD_OUT_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y
`endif
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t state_q, state_d;

  logic [XW-1:0] col_q, pcol;
  logic [YW-1:0] row_q;
  logic [XW-1:0] cx_q;
  logic [YW-1:0] cy_q;

  logic [11:0] line_a [IMG_WIDTH];
  logic [11:0] line_b [IMG_WIDTH];
  logic [11:0] top_q [3];
  logic [11:0] mid_q [3];
  logic [11:0] bot_q [3];

  logic accept, step, emit, done, restart, wr_en;
  logic [11:0] push_pixel, rd_a, rd_b;
  logic lz, rz, uz, dz;
  logic [107:0] win_next;

  assign bus.in_ready = ~reset & (state_q != FLUSH);
  assign accept       = bus.in_valid & bus.in_ready;

  // A frame start always restarts the column pointer at 0, whatever state
  // the old frame left it in. During FLUSH the pipeline keeps stepping with
  // a black pixel standing in for the (nonexistent) row below the image.
  assign pcol       = restart ? '0 : col_q;
  assign push_pixel = (state_q == FLUSH) ? 12'h000 : bus.in_pixel;
  assign rd_a       = line_a[pcol];
  assign rd_b       = line_b[pcol];
  assign wr_en      = step & (state_q != FLUSH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    emit    = 1'b0;
    done    = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && bus.in_sof) begin
          step    = 1'b1;
          restart = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          step = 1'b1;
          if (bus.in_sof)                          restart = 1'b1;
          else if (row_q == Y_ONE && col_q == '0)  state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          step = 1'b1;
          if (bus.in_sof) begin
            restart = 1'b1;
            state_d = FILL;
          end else begin
            emit = 1'b1;
            if (row_q == Y_LAST && col_q == X_LAST) state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        step = 1'b1;
        emit = 1'b1;
        if (cx_q == X_LAST && cy_q == Y_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The window is built from the values the registers are about to take
  // (shifted by one column), so it leaves one clock after the accepting
  // edge. The newest pixel is the down-right neighbour of the centre.
  // The registers may hold pixels from the wrong line or a previous frame at
  // image edges; the centre-coordinate masks hide those.
  always_comb begin
    lz = (cx_q == '0);
    rz = (cx_q == X_LAST);
    uz = (cy_q == '0);
    dz = (cy_q == Y_LAST);
    win_next = {mid_q[2],
                lz        ? 12'h000 : mid_q[1],
                rz        ? 12'h000 : rd_a,
                uz        ? 12'h000 : top_q[2],
                dz        ? 12'h000 : bot_q[2],
                (lz | uz) ? 12'h000 : top_q[1],
                (rz | uz) ? 12'h000 : rd_b,
                (lz | dz) ? 12'h000 : bot_q[1],
                (rz | dz) ? 12'h000 : push_pixel};
  end

  // line_a holds the previous line, line_b the one before it; no reset
  // because stale contents are always masked by padding.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_a[pcol] <= push_pixel;
      line_b[pcol] <= rd_a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q           <= '0;
      row_q           <= '0;
      cx_q            <= '0;
      cy_q            <= '0;
      top_q           <= '{default: 12'h000};
      mid_q           <= '{default: 12'h000};
      bot_q           <= '{default: 12'h000};
      bus.win_valid   <= 1'b0;
      bus.window_data <= '0;
      bus.frame_done  <= 1'b0;
`ifdef WINDOW_GEN_COORD_OUT_EN
      center_x        <= '0;
      center_y        <= '0;
`endif
    end else begin
      bus.win_valid  <= emit;
      bus.frame_done <= done;
      if (step) begin
        top_q <= '{top_q[1], top_q[2], rd_b};
        mid_q <= '{mid_q[1], mid_q[2], rd_a};
        bot_q <= '{bot_q[1], bot_q[2], push_pixel};
        col_q <= (pcol == X_LAST) ? '0 : pcol + 1'b1;
        if (restart)              row_q <= '0;
        else if (pcol == X_LAST)  row_q <= (row_q == Y_LAST) ? '0 : row_q + 1'b1;
      end
      if (restart) begin
        cx_q <= '0;
        cy_q <= '0;
      end else if (emit) begin
        bus.window_data <= win_next;
`ifdef WINDOW_GEN_COORD_OUT_EN
        center_x        <= cx_q;
        center_y        <= cy_q;
`endif
        if (cx_q == X_LAST) begin
          cx_q <= '0;
          cy_q <= (cy_q == Y_LAST) ? '0 : cy_q + 1'b1;
        end else begin
          cx_q <= cx_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3
//   Randomized bench for window_gen_3x3 at IMG_WIDTH=4, IMG_HEIGHT=3.
//   Expected windows come from a coordinate-based model of each frame;
//   a monitor collects every emitted window for comparison.
module tb_window_gen_3x3;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  window_gen_3x3_if bus();

`ifdef WINDOW_GEN_COORD_OUT_EN
  logic [1:0] center_x;
  logic [1:0] center_y;
`endif

  window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WINDOW_GEN_COORD_OUT_EN
    ,
    .center_x (center_x),
    .center_y (center_y)
`endif
  );

  typedef struct packed {
    logic        sof;
    logic [11:0] pix;
  } beat_t;

  int errors = 0;
  int checks = 0;

  beat_t        stim_q[$];
  logic [107:0] exp_q[$];
  logic         exp_done_q[$];
  logic [107:0] got_q[$];
  logic         got_done_q[$];
  int           got_acc_q[$];
  int           acc_cnt = 0;
  int           done_cnt = 0;
  int           exp_done_cnt = 0;
  logic         prev_xfer = 1'b0;
  logic         prev_ready = 1'b0;
  logic [11:0]  model_frame [NPIX];

  task automatic checkOutput(input string tag, input logic [107:0] observed,
                             input logic [107:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [11:0] pixAt(input int x, input int y);
    if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
    return model_frame[y*W + x];
  endfunction

  function automatic logic [107:0] expWindow(input int c);
    int x = c % W;
    int y = c / W;
    return {pixAt(x, y), pixAt(x-1, y), pixAt(x+1, y), pixAt(x, y-1),
            pixAt(x, y+1), pixAt(x-1, y-1), pixAt(x+1, y-1),
            pixAt(x-1, y+1), pixAt(x+1, y+1)};
  endfunction

  // Queue a frame of len pixels (sof on the first). A full frame yields all
  // W*H windows; a frame cut short after len pixels yields only the windows
  // whose down-right neighbour had arrived, i.e. c = 0 .. len-W-2.
  task automatic addFrame(input int len, input bit random_vals);
    int last_c;
    for (int n = 0; n < NPIX; n++) model_frame[n] = 12'h000;
    for (int n = 0; n < len; n++) begin
      model_frame[n] = random_vals ? 12'($urandom) : 12'(n + 1);
      stim_q.push_back('{sof: (n == 0), pix: model_frame[n]});
    end
    last_c = (len == NPIX) ? NPIX - 1 : len - W - 2;
    for (int c = 0; c <= last_c; c++) begin
      exp_q.push_back(expWindow(c));
      exp_done_q.push_back(len == NPIX && c == NPIX - 1);
    end
    if (len == NPIX) exp_done_cnt++;
  endtask

  task automatic addJunk(input int k);
    for (int i = 0; i < k; i++) stim_q.push_back('{sof: 1'b0, pix: 12'($urandom)});
  endtask

  // Called and returns on a falling edge. Each beat is held until a rising
  // edge sees in_ready.
  task automatic applyStimulus(input int duty);
    beat_t b;
    int guard;
    while (stim_q.size() > 0) begin
      b = stim_q.pop_front();
      while ($urandom_range(0, 99) >= duty) begin
        bus.in_valid = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_sof   = b.sof;
      bus.in_pixel = b.pix;
      guard = 0;
      while (!bus.in_ready) begin
        @(negedge clk);
        guard++;
        if (guard > 100) begin
          errors++;
          $display("[TB] FAIL ready_timeout: got in_ready=0 expected 1 within 100 cycles");
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $fatal(1, "[TB] stalled");
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic idleCycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  task automatic clearScoreboard();
    exp_q.delete();
    exp_done_q.delete();
    got_q.delete();
    got_done_q.delete();
    got_acc_q.delete();
    acc_cnt      = 0;
    done_cnt     = 0;
    exp_done_cnt = 0;
  endtask

  task automatic compareRun(input string name);
    int n;
    checkOutput({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_win%0d", name, i), got_q[i], exp_q[i]);
      checkOutput($sformatf("%s_done%0d", name, i), got_done_q[i], exp_done_q[i]);
    end
    checkOutput({name, "_done_pulses"}, done_cnt, exp_done_cnt);
  endtask

  always @(posedge clk) begin
    prev_xfer  = bus.in_valid && bus.in_ready;
    prev_ready = bus.in_ready;
    if (prev_xfer) acc_cnt++;
  end

  // A window may only follow an edge with a transfer or a flush (ready low).
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.frame_done) done_cnt++;
      if (bus.win_valid) begin
        got_q.push_back(bus.window_data);
        got_done_q.push_back(bus.frame_done);
        got_acc_q.push_back(acc_cnt);
        checkOutput("win_needs_xfer", prev_xfer || !prev_ready, 1'b1);
      end
    end
  end

  initial begin
    #300000;
    errors++;
    $display("[TB] FAIL watchdog: got no finish expected finish before 300000");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [107:0] w;
    int n;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_pixel = 12'h000;
    idleCycles(3);
    checkOutput("rst_in_ready", bus.in_ready, 1'b0);
    checkOutput("rst_win_valid", bus.win_valid, 1'b0);
    checkOutput("rst_window_data", bus.window_data, '0);
    checkOutput("rst_frame_done", bus.frame_done, 1'b0);
    reset = 1'b0;
    #1;
    checkOutput("idle_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);

    $display("[TB] directed frame 1..12, continuous valid");
    clearScoreboard();
    addFrame(NPIX, 1'b0);
    applyStimulus(100);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checkOutput("flush_ready_low_cycles", n, 5);
    checkOutput("ready_after_flush", bus.in_ready, 1'b1);
    idleCycles(3);
    compareRun("seq");
    if (got_q.size() == NPIX) begin
      checkOutput("first_win_after_pix6", got_acc_q[0], 6);
      w = {12'd1, 12'd0, 12'd2, 12'd0, 12'd5, 12'd0, 12'd0, 12'd0, 12'd6};
      checkOutput("win_c0", got_q[0], w);
      w = {12'd6, 12'd5, 12'd7, 12'd2, 12'd10, 12'd1, 12'd3, 12'd9, 12'd11};
      checkOutput("win_c5", got_q[5], w);
      w = {12'd12, 12'd11, 12'd0, 12'd8, 12'd0, 12'd7, 12'd0, 12'd0, 12'd0};
      checkOutput("win_c11", got_q[11], w);
      checkOutput("done_c11", got_done_q[11], 1'b1);
    end

    $display("[TB] same frame, gapped valid");
    for (int r = 0; r < 3; r++) begin
      clearScoreboard();
      addFrame(NPIX, 1'b0);
      applyStimulus(50);
      idleCycles(10);
      compareRun($sformatf("gap%0d", r));
    end

    $display("[TB] dropped pixels, aborted frame, then full frame");
    for (int r = 0; r < 2; r++) begin
      clearScoreboard();
      addJunk(5);
      addFrame(7, 1'b1);
      addFrame(NPIX, 1'b1);
      applyStimulus(70);
      idleCycles(10);
      compareRun($sformatf("abort%0d", r));
    end

    $display("[TB] reset during flush");
    clearScoreboard();
    addFrame(NPIX, 1'b1);
    applyStimulus(100);
    idleCycles(2);
    reset = 1'b1;
    #1;
    checkOutput("flushrst_win_valid", bus.win_valid, 1'b0);
    checkOutput("flushrst_window_data", bus.window_data, '0);
    checkOutput("flushrst_frame_done", bus.frame_done, 1'b0);
    checkOutput("flushrst_in_ready", bus.in_ready, 1'b0);
    idleCycles(2);
    reset = 1'b0;
    @(negedge clk);
    clearScoreboard();
    addFrame(NPIX, 1'b1);
    applyStimulus(60);
    idleCycles(10);
    compareRun("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
